periph_axi_slice: RTL and testbench

PERIPH_AXI_SLICE -- requirements
Module: periph_axi_slice

---
 rtl/periph_axi_pkg.sv | 19 +
 rtl/periph_axi_slice_if.sv | 54 +++++
 rtl/axi_skid_buf.sv | 84 ++++++++
 rtl/periph_axi_slice.sv | 132 +++++++++++++
 tb/tb_periph_axi_slice.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_axi_pkg.sv
// periph_axi_pkg: shared widths, skid state enum and the R-last bit index
// for the peripheral AXI register slice.
package periph_axi_pkg;

  localparam int AW_W_C = 44;
  localparam int W_W_C  = 37;
  localparam int B_W_C  = 6;
  localparam int AR_W_C = 44;
  localparam int R_W_C  = 39;

  localparam int R_LAST_BIT = 0;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_e;

endpackage

// File: rtl/periph_axi_slice_if.sv
// periph_axi_slice_if: five AXI-style channels (aw, w, b, ar, r) as
// valid/ready/msg triples. master drives aw/w/ar and the b/r readies.
interface periph_axi_slice_if
  import periph_axi_pkg::*;
#(
  parameter int AW_W = AW_W_C,
  parameter int W_W  = W_W_C,
  parameter int B_W  = B_W_C,
  parameter int R_W  = R_W_C
);

  logic            aw_valid;
  logic            aw_ready;
  logic [AW_W-1:0] aw_msg;
  logic            w_valid;
  logic            w_ready;
  logic [W_W-1:0]  w_msg;
  logic            b_valid;
  logic            b_ready;
  logic [B_W-1:0]  b_msg;
  logic            ar_valid;
  logic            ar_ready;
  logic [AW_W-1:0] ar_msg;
  logic            r_valid;
  logic            r_ready;
  logic [R_W-1:0]  r_msg;

  modport master (
    output aw_valid, aw_msg,
    input  aw_ready,
    output w_valid, w_msg,
    input  w_ready,
    input  b_valid, b_msg,
    output b_ready,
    output ar_valid, ar_msg,
    input  ar_ready,
    input  r_valid, r_msg,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_msg,
    output aw_ready,
    input  w_valid, w_msg,
    output w_ready,
    output b_valid, b_msg,
    input  b_ready,
    input  ar_valid, ar_msg,
    output ar_ready,
    output r_valid, r_msg,
    input  r_ready
  );

endinterface

// File: rtl/axi_skid_buf.sv
// axi_skid_buf: 2-entry skid buffer, ready/valid/msg all from flops.
// Ports: clk_i, rst_i, in_valid_i/in_ready_o/in_msg_i, out_valid_o/out_ready_i/out_msg_o.
module axi_skid_buf
  import periph_axi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_msg_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_msg_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_rdy_q, in_rdy_d;
  logic             out_vld_q, out_vld_d;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = in_valid_i & in_rdy_q;
  assign out_hs = out_vld_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = ONE;
          head_d  = in_msg_i;
        end
      end
      ONE: begin
        if (in_hs && !out_hs) begin
          state_d = FULL;
          skid_d  = in_msg_i;
        end else if (in_hs && out_hs) begin
          head_d = in_msg_i;
        end else if (out_hs) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // oldest beat sits in head; the skid entry moves up when it leaves
        if (out_hs) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_rdy_d  = (state_d != FULL);
    out_vld_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  // reset forces the handshake outputs quiet during the reset cycle itself
  assign in_ready_o  = in_rdy_q & ~rst_i;
  assign out_valid_o = out_vld_q & ~rst_i;
  assign out_msg_o   = rst_i ? '0 : head_q;

endmodule

// File: rtl/periph_axi_slice.sv
// periph_axi_slice: five skid-buffered AXI channels with outstanding limits.
// Ports: clock, reset, up (slave side), dn (master side), wr_cnt_o, rd_cnt_o.
module periph_axi_slice
  import periph_axi_pkg::*;
#(
  parameter int AW_W      = AW_W_C,
  parameter int W_W       = W_W_C,
  parameter int B_W       = B_W_C,
  parameter int R_W       = R_W_C,
  parameter int MAX_OUTST = 8
) (
  input  logic                clock,
  input  logic                reset,
  periph_axi_slice_if.slave   up,
  periph_axi_slice_if.master  dn,
  output logic [3:0]          wr_cnt_o,
  output logic [3:0]          rd_cnt_o
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUTST);

  logic [3:0]     wr_cnt_q, wr_cnt_d;
  logic [3:0]     rd_cnt_q, rd_cnt_d;
  logic           aw_gate, ar_gate;
  logic           aw_vld_s, aw_rdy_s;
  logic           ar_vld_s, ar_rdy_s;
  logic           b_vld_s, r_vld_s;
  logic [R_W-1:0] r_msg_s;
  logic           wr_inc, wr_dec;
  logic           rd_inc, rd_dec;

  // gating from registered counts keeps the ready outputs flop-driven
  assign aw_gate  = (wr_cnt_q == MAX_C);
  assign ar_gate  = (rd_cnt_q == MAX_C);
  assign aw_vld_s = up.aw_valid & ~aw_gate;
  assign ar_vld_s = up.ar_valid & ~ar_gate;

  assign up.aw_ready = aw_rdy_s & ~aw_gate;
  assign up.ar_ready = ar_rdy_s & ~ar_gate;
  assign up.b_valid  = b_vld_s;
  assign up.r_valid  = r_vld_s;
  assign up.r_msg    = r_msg_s;

  axi_skid_buf #(.WIDTH(AW_W)) u_aw (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (aw_vld_s),
    .in_ready_o (aw_rdy_s),
    .in_msg_i   (up.aw_msg),
    .out_valid_o(dn.aw_valid),
    .out_ready_i(dn.aw_ready),
    .out_msg_o  (dn.aw_msg)
  );

  axi_skid_buf #(.WIDTH(W_W)) u_w (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (up.w_valid),
    .in_ready_o (up.w_ready),
    .in_msg_i   (up.w_msg),
    .out_valid_o(dn.w_valid),
    .out_ready_i(dn.w_ready),
    .out_msg_o  (dn.w_msg)
  );

  axi_skid_buf #(.WIDTH(B_W)) u_b (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (dn.b_valid),
    .in_ready_o (dn.b_ready),
    .in_msg_i   (dn.b_msg),
    .out_valid_o(b_vld_s),
    .out_ready_i(up.b_ready),
    .out_msg_o  (up.b_msg)
  );

  axi_skid_buf #(.WIDTH(AW_W)) u_ar (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (ar_vld_s),
    .in_ready_o (ar_rdy_s),
    .in_msg_i   (up.ar_msg),
    .out_valid_o(dn.ar_valid),
    .out_ready_i(dn.ar_ready),
    .out_msg_o  (dn.ar_msg)
  );

  axi_skid_buf #(.WIDTH(R_W)) u_r (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (dn.r_valid),
    .in_ready_o (dn.r_ready),
    .in_msg_i   (dn.r_msg),
    .out_valid_o(r_vld_s),
    .out_ready_i(up.r_ready),
    .out_msg_o  (r_msg_s)
  );

  assign wr_inc = aw_vld_s & aw_rdy_s;
  assign wr_dec = b_vld_s & up.b_ready;
  assign rd_inc = ar_vld_s & ar_rdy_s;
  assign rd_dec = r_vld_s & up.r_ready & r_msg_s[R_LAST_BIT];

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_inc && !wr_dec) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end else if (!wr_inc && wr_dec && wr_cnt_q != 4'd0) begin
      wr_cnt_d = wr_cnt_q - 4'd1;
    end
    if (rd_inc && !rd_dec) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end else if (!rd_inc && rd_dec && rd_cnt_q != 4'd0) begin
      rd_cnt_d = rd_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt_q <= 4'd0;
      rd_cnt_q <= 4'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

endmodule

// File: tb/tb_periph_axi_slice.sv
// tb_periph_axi_slice: directed scenarios plus random traffic, checked
// every cycle against a FIFO-occupancy model of the five channels.
module tb_periph_axi_slice;

  localparam int MAXO = 8;

  logic clk;
  logic rst;
  logic [3:0] wr_cnt, rd_cnt;

  // channel index: 0 aw, 1 w, 2 b, 3 ar, 4 r
  logic        iv[5];
  logic [63:0] im[5];
  logic        ordy[5];
  logic        ir[5];
  logic        ov[5];
  logic [63:0] om[5];

  int          occ[5];
  logic [63:0] ent[5][2];
  int          wc, rc;

  int  n_chk;
  int  n_fail;
  bit  chk_on;

  periph_axi_slice_if up_if ();
  periph_axi_slice_if dn_if ();

  periph_axi_slice #(.MAX_OUTST(MAXO)) dut (
    .clock   (clk),
    .reset   (rst),
    .up      (up_if),
    .dn      (dn_if),
    .wr_cnt_o(wr_cnt),
    .rd_cnt_o(rd_cnt)
  );

  assign up_if.aw_valid = iv[0];
  assign up_if.aw_msg   = im[0][43:0];
  assign up_if.w_valid  = iv[1];
  assign up_if.w_msg    = im[1][36:0];
  assign dn_if.b_valid  = iv[2];
  assign dn_if.b_msg    = im[2][5:0];
  assign up_if.ar_valid = iv[3];
  assign up_if.ar_msg   = im[3][43:0];
  assign dn_if.r_valid  = iv[4];
  assign dn_if.r_msg    = im[4][38:0];

  assign dn_if.aw_ready = ordy[0];
  assign dn_if.w_ready  = ordy[1];
  assign up_if.b_ready  = ordy[2];
  assign dn_if.ar_ready = ordy[3];
  assign up_if.r_ready  = ordy[4];

  assign ir[0] = up_if.aw_ready;
  assign ir[1] = up_if.w_ready;
  assign ir[2] = dn_if.b_ready;
  assign ir[3] = up_if.ar_ready;
  assign ir[4] = dn_if.r_ready;

  assign ov[0] = dn_if.aw_valid;
  assign ov[1] = dn_if.w_valid;
  assign ov[2] = up_if.b_valid;
  assign ov[3] = dn_if.ar_valid;
  assign ov[4] = up_if.r_valid;

  assign om[0] = 64'(dn_if.aw_msg);
  assign om[1] = 64'(dn_if.w_msg);
  assign om[2] = 64'(up_if.b_msg);
  assign om[3] = 64'(dn_if.ar_msg);
  assign om[4] = 64'(up_if.r_msg);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int c);
    int w;
    case (c)
      0: w = 44;
      1: w = 37;
      2: w = 6;
      3: w = 44;
      default: w = 39;
    endcase
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic bit m_rdy(int c);
    if (occ[c] >= 2) return 1'b0;
    if (c == 0 && wc == MAXO) return 1'b0;
    if (c == 3 && rc == MAXO) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: each channel is a depth-2 FIFO; counters follow handshakes
  task automatic model_step();
    bit ih[5];
    bit oh[5];
    bit rl;
    if (rst) begin
      for (int c = 0; c < 5; c++) occ[c] = 0;
      wc = 0;
      rc = 0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        ih[c] = iv[c] && m_rdy(c);
        oh[c] = (occ[c] > 0) && ordy[c];
      end
      rl = oh[4] && ent[4][0][0];
      for (int c = 0; c < 5; c++) begin
        if (oh[c]) begin
          ent[c][0] = ent[c][1];
          occ[c]--;
        end
        if (ih[c]) begin
          ent[c][occ[c]] = im[c] & mk(c);
          occ[c]++;
        end
      end
      wc = wc + int'(ih[0]) - int'(oh[2]);
      if (wc < 0) wc = 0;
      rc = rc + int'(ih[3]) - int'(rl);
      if (rc < 0) rc = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    for (int c = 0; c < 5; c++) begin
      iv[c] = 1'b0;
      im[c] = 64'd0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < 5; c++) begin
        bit er;
        bit ev;
        er = !rst && m_rdy(c);
        ev = !rst && (occ[c] > 0);
        chk($sformatf("ch%0d_in_ready", c), 64'(ir[c]), 64'(er));
        chk($sformatf("ch%0d_out_valid", c), 64'(ov[c]), 64'(ev));
        if (ev) chk($sformatf("ch%0d_out_msg", c), om[c], ent[c][0]);
        else if (rst) chk($sformatf("ch%0d_rst_msg", c), om[c], 64'd0);
      end
      chk("wr_cnt", 64'(wr_cnt), 64'(wc));
      chk("rd_cnt", 64'(rd_cnt), 64'(rc));
    end
  end

  initial begin
    logic [63:0] p;
    int n;
    n_chk  = 0;
    n_fail = 0;
    chk_on = 1'b0;
    wc = 0;
    rc = 0;
    rst = 1'b1;
    idle();
    for (int c = 0; c < 5; c++) begin
      occ[c] = 0;
      ordy[c] = 1'b0;
    end
    repeat (3) cyc();
    chk_on = 1'b1;
    chk("rst_up_aw_ready", 64'(ir[0]), 64'd0);
    chk("rst_dn_aw_valid", 64'(ov[0]), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_up_aw_ready", 64'(ir[0]), 64'd1);
    chk("post_rst_wr_cnt", 64'(wr_cnt), 64'd0);

    // single beat, one cycle latency
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    im[0] = 64'h0_0000_1000;
    #1;
    chk("single_not_early", 64'(ov[0]), 64'd0);
    cyc();
    iv[0] = 1'b0;
    chk("single_dn_aw_valid", 64'(ov[0]), 64'd1);
    chk("single_dn_aw_msg", om[0], 64'h1000);
    chk("single_wr_cnt", 64'(wr_cnt), 64'd1);
    cyc();
    chk("single_drained", 64'(ov[0]), 64'd0);

    // fill AW skid, then reset discards it
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    im[0] = 64'hA_AAAA_0001;
    cyc();
    im[0] = 64'hA_AAAA_0002;
    cyc();
    iv[0] = 1'b0;
    chk("aw_full_ready", 64'(ir[0]), 64'd0);
    chk("aw_full_wr_cnt", 64'(wr_cnt), 64'd3);
    rst = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("mid_rst_ready%0d", c), 64'(ir[c]), 64'd0);
      chk($sformatf("mid_rst_valid%0d", c), 64'(ov[c]), 64'd0);
    end
    cyc();
    rst = 1'b0;
    #1;
    chk("after_rst_aw_valid", 64'(ov[0]), 64'd0);
    chk("after_rst_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("after_rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("after_rst_aw_ready", 64'(ir[0]), 64'd1);
    chk("after_rst_w_ready", 64'(ir[1]), 64'd1);
    chk("after_rst_ar_ready", 64'(ir[3]), 64'd1);
    ordy[0] = 1'b1;
    cyc();
    chk("no_stale_aw", 64'(ov[0]), 64'd0);

    // AR backpressure and ordered release
    ordy[3] = 1'b0;
    iv[3] = 1'b1;
    im[3] = 64'h1_0000_00A1;
    cyc();
    chk("ar_ready_after_1", 64'(ir[3]), 64'd1);
    im[3] = 64'h1_0000_00A2;
    cyc();
    chk("ar_ready_after_2", 64'(ir[3]), 64'd0);
    im[3] = 64'h1_0000_00A3;
    cyc();
    cyc();
    chk("ar_stalled_ready", 64'(ir[3]), 64'd0);
    chk("ar_stalled_msg", om[3], 64'h1_0000_00A1);
    ordy[3] = 1'b1;
    cyc();
    chk("ar_rel_msg2", om[3], 64'h1_0000_00A2);
    cyc();
    iv[3] = 1'b0;
    chk("ar_rel_valid3", 64'(ov[3]), 64'd1);
    chk("ar_rel_msg3", om[3], 64'h1_0000_00A3);
    cyc();
    chk("ar_rel_empty", 64'(ov[3]), 64'd0);
    chk("ar_rd_cnt", 64'(rd_cnt), 64'd3);

    // R burst of 4, last only on the 4th beat
    ordy[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv[4] = (i < 4);
      im[4] = ((64'($urandom) << 8) & mk(4) & ~64'd1) | 64'(i == 3);
      cyc();
      chk($sformatf("r_burst_rd_cnt%0d", i), 64'(rd_cnt),
          (i == 4) ? 64'd2 : 64'd3);
    end
    iv[4] = 1'b0;

    // AW outstanding limit
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    n = 0;
    while (ir[0] && n < 20) begin
      im[0] = 64'(n);
      cyc();
      n++;
    end
    iv[0] = 1'b0;
    chk("aw_limit_beats", 64'(n), 64'd8);
    chk("aw_limit_wr_cnt", 64'(wr_cnt), 64'd8);
    chk("aw_limit_ready", 64'(ir[0]), 64'd0);
    ordy[2] = 1'b0;
    iv[2] = 1'b1;
    im[2] = 64'h15;
    cyc();
    iv[2] = 1'b0;
    chk("aw_still_blocked", 64'(ir[0]), 64'd0);
    ordy[2] = 1'b1;
    cyc();
    ordy[2] = 1'b0;
    chk("b_reopen_wr_cnt", 64'(wr_cnt), 64'd7);
    chk("b_reopen_ready", 64'(ir[0]), 64'd1);
    iv[2] = 1'b1;
    im[2] = 64'h2A;
    cyc();
    iv[2] = 1'b0;
    iv[0] = 1'b1;
    ordy[2] = 1'b1;
    cyc();
    iv[0] = 1'b0;
    ordy[2] = 1'b0;
    chk("aw_b_same_wr_cnt", 64'(wr_cnt), 64'd7);
    iv[0] = 1'b1;
    cyc();
    iv[0] = 1'b0;
    chk("aw_refill_wr_cnt", 64'(wr_cnt), 64'd8);
    chk("aw_refill_ready", 64'(ir[0]), 64'd0);

    // 100-beat W stream while AW is at its limit
    ordy[1] = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      iv[1] = (i < 100);
      im[1] = (64'(i) * 64'h9E37_79B9_7F4A_7C15) & mk(1);
      cyc();
      if (i < 100) begin
        p = (64'(i) * 64'h9E37_79B9_7F4A_7C15) & mk(1);
        chk($sformatf("w_stream_valid%0d", i), 64'(ov[1]), 64'd1);
        chk($sformatf("w_stream_msg%0d", i), om[1], p);
        chk($sformatf("w_stream_ready%0d", i), 64'(ir[1]), 64'd1);
      end
    end
    iv[1] = 1'b0;

    // random traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 5; c++) begin
        iv[c]   = ($urandom_range(0, 99) < 60);
        im[c]   = {$urandom, $urandom} & mk(c);
        ordy[c] = ($urandom_range(0, 99) < 65);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
